// File: rtl/uart_arb_pkg.sv
// Shared state encodings and defaults for the UART transmit arbiter.
// Used by uart_tx_arbiter and rr_pick.
package uart_arb_pkg;

    localparam int DEF_DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] HOLD      = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr,
// wrapping modulo N, returned as one-hot, index and any-flag.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan farthest-first so the nearest candidate after ptr wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = N; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j[IW-1:0]]) begin
                gnt             = '0;
                gnt[j[IW-1:0]]  = 1'b1;
                idx             = j[IW-1:0];
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter, locking per packet.
// Optional lock-release timeout in HOLD: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DEF_DATA_W
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_active
);

    localparam int IW = $clog2(N_REQ);

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              grant_active_q, grant_active_d;
    logic              last_q, last_d;

    logic [N_REQ-1:0]  pick_gnt, owner_oh, take_oh;
    logic [IW-1:0]     pick_idx, take_idx;
    logic              pick_any, owner_valid, take;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        owner_oh             = '0;
        owner_oh[grant_id_q] = 1'b1;
    end

    assign owner_valid = req_valid[grant_id_q];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
        tx_start_d     = 1'b0;
        req_ready_d    = '0;
        take           = 1'b0;
        take_idx       = grant_id_q;
        take_oh        = owner_oh;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_d          = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any && !tx_busy) begin
                    take     = 1'b1;
                    take_idx = pick_idx;
                    take_oh  = pick_gnt;
                end
            end
            LOAD: begin
                if (owner_valid && !tx_busy) begin
                    take = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (owner_valid && !tx_busy) begin
                    take = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Owner idle too long: give the transmitter back.
                if (!owner_valid) begin
                    if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        ptr_d          = grant_id_q;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q) begin
                        ptr_d          = grant_id_q;
                        grant_active_d = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            tx_data_d      = req_data[take_idx*DATA_W +: DATA_W];
            last_d         = req_last[take_idx];
            tx_start_d     = 1'b1;
            req_ready_d    = take_oh;
            grant_id_d     = take_idx;
            grant_active_d = 1'b1;
            state_d        = WAIT_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= IW'(N_REQ - 1);
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            tx_data_q      <= '0;
            last_q         <= 1'b0;
            tx_start_q     <= 1'b0;
            req_ready_q    <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            tx_data_q      <= tx_data_d;
            last_q         <= last_d;
            tx_start_q     <= tx_start_d;
            req_ready_q    <= req_ready_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign req_ready    = req_ready_q;
    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares a single UART byte transmitter among N_REQ byte-stream requesters. It replaces the fixed start/data sequencer in front of the transmitter. It accepts bytes over per-requester valid/ready handshakes and issues one-cycle tx_start pulses with registered tx_data. It holds the grant for a requester until that requester's packet ends (req_last), so multi-byte messages are never interleaved.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT_CYC, 1024, lock-release timeout in clk cycles (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  N_REQ  requester i has a byte on req_data[i]
req_data  input  N_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_last  input  N_REQ  byte is last of packet; qualified by req_valid
req_ready  output  N_REQ  one-hot, one-cycle pulse: byte of requester i consumed
tx_start  output  1  one-cycle pulse to transmitter: begin sending tx_data
tx_data  output  DATA_W  registered byte to transmitter; held until next load
tx_busy  input  1  transmitter shifting a frame
tx_done  input  1  one-cycle pulse at end of stop bit
grant_id  output  clog2(N_REQ)  index of current/last owner
grant_active  output  1  a requester currently owns the transmitter

Behaviour:
- Reset: req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_active=0, state=IDLE, rr pointer=N_REQ-1 (req 0 highest priority first). Reset mid-frame aborts the packet silently. The transmitter is reset independently.
- All outputs are registered.
- States: IDLE, LOAD, WAIT_DONE, HOLD.
- IDLE: if any req_valid and tx_busy=0, pick the first valid index searching from ptr+1 modulo N_REQ. At the clock edge: tx_data<=req_data[w], tx_start<=1, req_ready[w]<=1, grant_id<=w, grant_active<=1, go to WAIT_DONE. The byte is therefore sent the cycle after it is selected: tx_start/req_ready are high in cycle n+1 for selection in cycle n.
- Requesters hold req_data/req_last stable while valid && !ready. The byte is captured at the edge that sets req_ready.
- LOAD (owner-only select): same capture as IDLE, but only the owner is eligible. Entered from HOLD.
- WAIT_DONE: tx_start and req_ready return to 0 after one cycle. Wait for tx_done.
  - On tx_done, if the captured last=1: ptr<=grant_id, grant_active<=0, go to IDLE.
  - Otherwise go to HOLD.
- HOLD: owner locked. If req_valid[owner] and tx_busy=0, capture as in LOAD, then go to WAIT_DONE. Other requesters are ignored.
- tx_done while in IDLE or HOLD (spurious) is ignored.
- tx_busy=1 while in IDLE or HOLD blocks issuing; no byte is consumed.
- Back-to-back: minimum 2 cycles from tx_done to the next tx_start for the same owner.
- Only one req_ready bit is ever set. req_ready never asserts without a simultaneous tx_start.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: a counter runs in HOLD. If req_valid[owner] stays 0 for TIMEOUT_CYC consecutive cycles, the arbiter releases the lock (ptr<=owner, grant_active<=0, go to IDLE). The counter clears on entry to HOLD.
- Undefined: HOLD waits indefinitely. The counter and the TIMEOUT_CYC logic are absent.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, LOAD, WAIT_DONE, HOLD), default DATA_W constant.
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, ptr -> one-hot grant, index, any).

Test Plan:
- Single requester: req0 sends 0x55 with last=1 -> tx_start with tx_data=0x55 in the cycle after valid, req_ready[0] in the same cycle, grant_active drops after tx_done.
- Fairness: req0..3 continuously valid with single-byte packets -> grant order 0,1,2,3,0,1 and tx_data matches each source.
- Packet lock: req1 sends 3 bytes 0xA1,0xA2,0xA3 (last on third) while req2 is valid -> all three bytes sent before any req2 byte; grant_id=1 throughout.
- tx_busy held high for 20 cycles while req3 is valid -> no tx_start and no req_ready until tx_busy falls, then byte issued the next cycle.
- Reset asserted in WAIT_DONE mid-packet -> all outputs 0 immediately; after release, req0 wins first.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: owner stalls in HOLD -> lock released after 16 cycles and the next valid requester is served.
